// File: rtl/hazard_scoreboard_pkg.sv
// Shared CPU definitions for the hazard scoreboard: writer classes, register-file size,
// default load latency and forwarding-select encodings.
package hazard_scoreboard_pkg;

    localparam int unsigned NumRegs     = 32;
    localparam int unsigned LoadLatDflt = 1;
    localparam int unsigned RegIdxW     = 5;

    typedef enum logic [1:0] {
        WrAlu    = 2'd0,
        WrLoad   = 2'd1,
        WrMuldiv = 2'd2
    } wr_class_e;

    typedef enum logic [1:0] {
        FwdNone  = 2'd0,
        FwdExMem = 2'd1,
        FwdMemWb = 2'd2
    } fwd_sel_e;

    // Load and mul/div flags are mutually exclusive; neither set means an ALU writer.
    function automatic wr_class_e wr_class_of(input logic is_load, input logic is_muldiv);
        if (is_load) begin
            return WrLoad;
        end else if (is_muldiv) begin
            return WrMuldiv;
        end
        return WrAlu;
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// Per-register scoreboard state: load countdown and mul/div-pending flag.
module hazard_sb_entry
    import hazard_scoreboard_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr_en,
    input  wr_class_e  wr_class,
    input  logic [1:0] load_lat,
    input  logic       md_clr,
    output logic [1:0] cnt,
    output logic       mdp
);

    // A new writer supersedes any older state, including a same-cycle md_done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 2'd0;
            mdp <= 1'b0;
        end else if (wr_en) begin
            unique case (wr_class)
                WrLoad: begin
                    cnt <= load_lat;
                    mdp <= 1'b0;
                end
                WrMuldiv: begin
                    cnt <= 2'd0;
                    mdp <= 1'b1;
                end
                default: begin
                    cnt <= 2'd0;
                    mdp <= 1'b0;
                end
            endcase
        end else begin
            if (cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end
            if (md_clr) begin
                mdp <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: load-use and mul/div RAW stalls plus the
// single-unit mul/div structural hazard, with a free-running stall cycle counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NREG     = NumRegs,
    parameter int unsigned LOAD_LAT = LoadLatDflt
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [RegIdxW-1:0] id_rs1,
    input  logic [RegIdxW-1:0] id_rs2,
    input  logic               id_rs1_used,
    input  logic               id_rs2_used,
    input  logic               id_valid,
    input  logic [RegIdxW-1:0] id_rd,
    input  logic               id_regwrite,
    input  logic               id_is_load,
    input  logic               id_is_muldiv,
    input  logic               flush,
    input  logic               md_done,
    input  logic [RegIdxW-1:0] md_rd,
    output logic               stall,
    output logic               md_busy,
    output logic [31:0]        stall_count
);

    localparam int unsigned NSlots = 1 << RegIdxW;
    localparam logic [1:0] LoadLatCnt = 2'(LOAD_LAT);

    logic [NSlots-1:0] busy_vec;
    logic              rs1_haz;
    logic              rs2_haz;
    logic              struct_haz;
    logic              md_accept;
    logic              issue;
    wr_class_e         id_class;

    assign id_class  = wr_class_of(id_is_load, id_is_muldiv);
    // md_done is meaningless unless a mul/div is actually outstanding.
    assign md_accept = md_done & md_busy & (md_rd != '0);

    assign rs1_haz    = id_rs1_used & (id_rs1 != '0) & busy_vec[id_rs1];
    assign rs2_haz    = id_rs2_used & (id_rs2 != '0) & busy_vec[id_rs2];
    assign struct_haz = id_is_muldiv & md_busy & ~md_accept;
    assign stall      = id_valid & ~flush & (rs1_haz | rs2_haz | struct_haz);

    assign issue = id_valid & ~stall & ~flush & id_regwrite & (id_rd != '0)
                 & (32'(id_rd) < NREG);

    // Slot 0 and any index beyond NREG are never tracked and never hazardous.
    for (genvar r = 0; r < NSlots; r++) begin : g_slot
        if (r >= 1 && r < NREG) begin : g_entry
            logic [1:0] cnt;
            logic       mdp;

            hazard_sb_entry u_entry (
                .clk      (clk),
                .rstn     (rstn),
                .wr_en    (issue && (id_rd == RegIdxW'(r))),
                .wr_class (id_class),
                .load_lat (LoadLatCnt),
                .md_clr   (md_accept && (md_rd == RegIdxW'(r))),
                .cnt      (cnt),
                .mdp      (mdp)
            );

            assign busy_vec[r] = (cnt != 2'd0) | mdp;
        end else begin : g_none
            assign busy_vec[r] = 1'b0;
        end
    end

    // A new mul/div issue in the same cycle as md_done keeps the unit busy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            md_busy <= 1'b0;
        end else if (issue && id_class == WrMuldiv) begin
            md_busy <= 1'b1;
        end else if (md_accept) begin
            md_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_count <= 32'd0;
        end else if (stall) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, mul/div RAW, structural, flush and reset cases.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rstn;
    logic [4:0]  id_rs1, id_rs2, id_rd, md_rd;
    logic        id_rs1_used, id_rs2_used, id_valid, id_regwrite;
    logic        id_is_load, id_is_muldiv, flush, md_done;
    logic        stall, md_busy;
    logic [31:0] stall_count;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_sc;

    hazard_scoreboard dut (
        .clk          (clk),
        .rstn         (rstn),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_valid     (id_valid),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_is_load   (id_is_load),
        .id_is_muldiv (id_is_muldiv),
        .flush        (flush),
        .md_done      (md_done),
        .md_rd        (md_rd),
        .stall        (stall),
        .md_busy      (md_busy),
        .stall_count  (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic rw, input logic ld,
                          input logic md, input logic [4:0] s1, input logic u1,
                          input logic [4:0] s2, input logic u2);
        id_valid     = v;
        id_rd        = rd;
        id_regwrite  = rw;
        id_is_load   = ld;
        id_is_muldiv = md;
        id_rs1       = s1;
        id_rs1_used  = u1;
        id_rs2       = s2;
        id_rs2_used  = u2;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        flush   = 1'b0;
        md_done = 1'b0;
        md_rd   = 5'd0;
    endtask

    // Called just after a rising edge: check stall mid-cycle, then advance one cycle.
    task automatic cyc(input string tag, input logic exp_stall);
        #1;
        check_eq(tag, {31'd0, stall}, {31'd0, exp_stall});
        if (exp_stall) exp_sc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_sc   = 32'd0;
        idle();
        rstn = 1'b0;

        // Reset: mul/div in ID must not stall while nothing is busy.
        set_id(1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        #3;
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_busy", {31'd0, md_busy}, 32'd0);
        check_eq("rst_count", stall_count, 32'd0);
        #9;
        rstn = 1'b1;
        idle();
        @(posedge clk);
        #1;

        // lw x5 ; add x6,x5,x1 -> one stall cycle
        set_id(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("lw_x5", 1'b0);
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 5'd1, 1'b1);
        cyc("add_dep", 1'b1);
        check_eq("count_lw", stall_count, 32'd1);
        cyc("add_go", 1'b0);
        check_eq("count_lw_after", stall_count, 32'd1);

        // Flushed lw x5 leaves no countdown behind
        set_id(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        flush = 1'b1;
        cyc("lw_flushed", 1'b0);
        flush = 1'b0;
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        cyc("add_after_flush", 1'b0);

        // Writes to x0 are discarded; x0 never hazardous
        set_id(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("lw_x0", 1'b0);
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
        cyc("read_x0", 1'b0);

        // div x7 ; sub x8,x7 waits 10 cycles for md_done
        set_id(1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
        cyc("div_x7", 1'b0);
        check_eq("busy_div_x7", {31'd0, md_busy}, 32'd1);
        set_id(1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                md_done = 1'b1;
                md_rd   = 5'd7;
            end
            cyc("sub_wait", 1'b1);
        end
        md_done = 1'b0;
        check_eq("busy_after_done7", {31'd0, md_busy}, 32'd0);
        cyc("sub_go", 1'b0);
        check_eq("count_div", stall_count, 32'd11);

        // Structural: second mul while busy, released by same-cycle md_done
        set_id(1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
        cyc("mul_x10", 1'b0);
        set_id(1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        cyc("mul_struct", 1'b1);
        md_done = 1'b1;
        md_rd   = 5'd10;
        cyc("mul_with_done", 1'b0);
        md_done = 1'b0;
        check_eq("busy_kept", {31'd0, md_busy}, 32'd1);
        set_id(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0);
        cyc("read_x10", 1'b0);
        set_id(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1);
        cyc("read_x11", 1'b1);
        idle();
        md_done = 1'b1;
        md_rd   = 5'd11;
        cyc("done_x11", 1'b0);
        md_done = 1'b0;
        check_eq("busy_after_done11", {31'd0, md_busy}, 32'd0);

        // div x9 superseded by addi x9; later md_done for x9 is harmless
        set_id(1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
        cyc("div_x9", 1'b0);
        set_id(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);
        cyc("addi_x9", 1'b0);
        set_id(1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
        cyc("read_x9", 1'b0);
        md_done = 1'b1;
        md_rd   = 5'd9;
        cyc("read_x9_done", 1'b0);
        md_done = 1'b0;
        check_eq("busy_after_done9", {31'd0, md_busy}, 32'd0);

        // md_done with md_rd=0 is ignored
        set_id(1'b1, 5'd16, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("div_x16", 1'b0);
        idle();
        md_done = 1'b1;
        md_rd   = 5'd0;
        cyc("done_rd0", 1'b0);
        md_done = 1'b0;
        check_eq("busy_rd0_ignored", {31'd0, md_busy}, 32'd1);
        set_id(1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 5'd16, 1'b1, 5'd0, 1'b0);
        md_done = 1'b1;
        md_rd   = 5'd16;
        cyc("read_x16", 1'b1);
        md_done = 1'b0;
        cyc("read_x16_go", 1'b0);
        check_eq("count_mid", stall_count, exp_sc);

        // Load countdown expires without a reader
        set_id(1'b1, 5'd14, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("lw_x14", 1'b0);
        idle();
        cyc("gap", 1'b0);
        set_id(1'b1, 5'd18, 1'b1, 1'b0, 1'b0, 5'd14, 1'b1, 5'd0, 1'b0);
        cyc("read_x14", 1'b0);

        // Reset mid-operation discards the pending div x3
        set_id(1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
        cyc("div_x3", 1'b0);
        set_id(1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0);
        #1;
        check_eq("read_x3_pre", {31'd0, stall}, 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("rst_mid_busy", {31'd0, md_busy}, 32'd0);
        check_eq("rst_mid_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_mid_count", stall_count, 32'd0);
        exp_sc = 32'd0;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        md_done = 1'b1;
        md_rd   = 5'd3;
        cyc("read_x3_post", 1'b0);
        md_done = 1'b0;
        check_eq("busy_post_rst", {31'd0, md_busy}, 32'd0);
        check_eq("count_post_rst", stall_count, exp_sc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The module SHALL have parameter NREG, default 32, meaning the number of architectural registers tracked (x0 included, never tracked).
REQ-002 The module SHALL have parameter LOAD_LAT, default 1, meaning load-use stall cycles before a load result is forwardable.
REQ-003 The module SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-004 The module SHALL have ports: rstn  input  1  asynchronous active-low reset.
REQ-005 The module SHALL have ports: id_rs1, id_rs2  input  5  ID-stage source register numbers.
REQ-006 The module SHALL have ports: id_rs1_used, id_rs2_used  input  1  the ID instruction reads that source.
REQ-007 The module SHALL have ports: id_valid  input  1  a valid instruction is in ID.
REQ-008 The module SHALL have ports: id_rd  input  5  destination register; id_regwrite  input  1  the instruction writes rd.
REQ-009 The module SHALL have ports: id_is_load, id_is_muldiv  input  1  writer class (mutually exclusive; neither means ALU).
REQ-010 The module SHALL have ports: flush  input  1  the ID instruction is squashed this cycle (taken branch in EX).
REQ-011 The module SHALL have ports: md_done  input  1  one-cycle pulse when the multi-cycle mul/div unit finishes; md_rd  input  5  its destination.
REQ-012 The module SHALL have ports: stall  output  1  hold PC and IF/ID and insert a bubble into ID/EX.
REQ-013 The module SHALL have ports: md_busy  output  1  a mul/div is outstanding.
REQ-014 The module SHALL have ports: stall_count  output  32  count of stalled cycles.

Function
REQ-015 Per register r (1..NREG-1) the block SHALL hold cnt[r] (2 bits, load countdown) and mdp[r] (1 bit, mul/div pending).
REQ-016 A source s SHALL be hazardous when it is used, s!=0, and cnt[s]!=0 or mdp[s]=1.
REQ-017 The structural hazard SHALL be id_is_muldiv & md_busy & ~md_done.
REQ-018 stall SHALL be combinational: id_valid & ~flush & (rs1 hazard | rs2 hazard | structural hazard).
REQ-019 Issue SHALL occur in cycle t when id_valid & ~stall & ~flush & id_regwrite & id_rd!=0.
REQ-020 On issue of a load, cnt[id_rd] SHALL become LOAD_LAT and mdp[id_rd] 0 at edge t+1.
REQ-021 On issue of a mul/div, mdp[id_rd] SHALL become 1, cnt[id_rd] 0, and md_busy 1 at edge t+1.
REQ-022 On issue of an ALU writer, cnt[id_rd] and mdp[id_rd] SHALL become 0 (forwarding covers it; the new writer supersedes older state).
REQ-023 Each cycle, every nonzero cnt not being written by an issue SHALL decrement by 1, saturating at 0.
REQ-024 md_done SHALL clear mdp[md_rd] and md_busy at the next edge.
REQ-025 If md_done and an issue target the same register in one cycle, the issue SHALL win.
REQ-026 md_done and a new mul/div issue in the same cycle SHALL leave md_busy at 1.
REQ-027 md_done with md_rd=0, or while md_busy=0, SHALL be ignored.
REQ-028 A flushed or stalled ID instruction SHALL NOT modify state; in-flight countdowns and mdp SHALL be unaffected by flush.
REQ-029 stall_count SHALL increment by 1 on every cycle with stall=1 and wrap from 2^32-1 to 0.
REQ-030 Register 0 SHALL never be hazardous; writes to index 0 SHALL be discarded.

Reset
REQ-031 While rstn=0, all cnt, mdp, md_busy and stall_count SHALL be 0 asynchronously; stall SHALL then reflect only the structural term, which is 0.
REQ-032 Reset asserted mid-operation SHALL discard all outstanding entries; a later md_done for a pre-reset mul/div SHALL be ignored per REQ-027.

Structure
REQ-033 Writer-class encoding, NREG and the LOAD_LAT default SHALL live in the shared CPU package alongside the forwarding-select constants.
REQ-034 One sub-module, hazard_sb_entry (per-register cnt/mdp state with its update logic), SHALL be instantiated once per register index 1..NREG-1.

Verification
REQ-035 Back-to-back lw x5 then add x6,x5,x1 -> stall=1 for exactly 1 cycle, stall_count=1, add issues the next cycle.
REQ-036 div x7 issued, dependent sub x8,x7 in ID, md_done with md_rd=7 after 10 cycles -> stall held 10 cycles, deasserted the cycle after md_done.
REQ-037 Second mul issued while md_busy=1 -> stall=1 (structural); with md_done in the same cycle -> stall=0 and md_busy stays 1.
REQ-038 lw x5 in ID with flush=1, then add x6,x5 -> no stall, cnt[5] stays 0.
REQ-039 div x9 outstanding, ALU addi x9 issued, then md_done with md_rd=9 -> mdp[9] cleared; a reader of x9 does not stall after the addi.
REQ-040 rstn pulsed low while div x3 is pending -> md_busy=0 immediately, reader of x3 does not stall, stall_count=0.
